// File: rtl/icache_resp_pkg.sv
// Shared constants and FSM state encoding for the instruction cache responder.
package icache_resp_pkg;

  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

  typedef enum logic [2:0] {
    ICACHE_S_IDLE   = 3'd0,
    ICACHE_S_LOOKUP = 3'd1,
    ICACHE_S_MISS   = 3'd2,
    ICACHE_S_REFILL = 3'd3,
    ICACHE_S_RESP   = 3'd4
  } icache_state_e;

endpackage

// File: rtl/icache_resp_line_ram.sv
// Tag and data storage for the direct-mapped icache. One write port (per-word
// data write plus tag write) and one synchronous read port returning the tag
// and the whole line. Valid bits live in the parent so they can be reset.
module icache_line_ram #(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 4,
  parameter int TAG_W    = 32 - INDEX_W - OFFSET_W,
  parameter int WORDS    = 1 << (OFFSET_W - 2),
  parameter int WW       = OFFSET_W - 2
) (
  input  logic                   clk,
  input  logic                   re,
  input  logic [INDEX_W-1:0]     r_idx,
  output logic [TAG_W-1:0]       r_tag,
  output logic [WORDS-1:0][31:0] r_line,
  input  logic                   we_word,
  input  logic [INDEX_W-1:0]     w_idx,
  input  logic [WW-1:0]          w_word,
  input  logic [31:0]            w_data,
  input  logic                   we_tag,
  input  logic [TAG_W-1:0]       w_tag
);

  localparam int SETS = 1 << INDEX_W;

  logic [TAG_W-1:0]       tag_mem  [SETS];
  logic [WORDS-1:0][31:0] data_mem [SETS];
  logic [TAG_W-1:0]       r_tag_q;
  logic [WORDS-1:0][31:0] r_line_q;

  // Refill writes: one word per beat, tag on the last beat
  always_ff @(posedge clk) begin
    if (we_word) data_mem[w_idx][w_word] <= w_data;
    if (we_tag)  tag_mem[w_idx]          <= w_tag;
  end

  // Registered read at request acceptance, consumed in the following cycle
  always_ff @(posedge clk) begin
    if (re) begin
      r_tag_q  <= tag_mem[r_idx];
      r_line_q <= data_mem[r_idx];
    end
  end

  assign r_tag  = r_tag_q;
  assign r_line = r_line_q;

endmodule

// File: rtl/icache_resp.sv
// Blocking direct-mapped instruction cache responder. Hits answer one cycle
// after acceptance; misses and uncached fetches go through a single read port.
// Optional: define ICACHE_PERF_EN to add hit_cnt / miss_cnt counter ports.
module icache_resp
  import icache_resp_pkg::*;
#(
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid,
  input  logic [31:0] iaddr,
  input  logic        uncached,
  input  logic        cancel,
  output logic        addr_ok,
  output logic [31:0] rdata,
  output logic        data_ok,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << (OFFSET_W - 2);
  localparam int WW    = OFFSET_W - 2;
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W;
  localparam logic [WW-1:0] CNT_ONE = 1;

  icache_state_e          state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic                   unc_q, unc_d;
  logic [SETS-1:0]        set_vld_q, set_vld_d;
  logic [WW-1:0]          cnt_q, cnt_d;
  logic [31:0]            cap_q, cap_d;
  logic [31:0]            rdata_q;
  logic                   dropped_q, dropped_d;

  logic [TAG_W-1:0]       ram_tag;
  logic [WORDS-1:0][31:0] ram_line;
  logic [INDEX_W-1:0]     idx_r;
  logic [WW-1:0]          off_r;
  logic [TAG_W-1:0]       tag_r;
  logic                   hit, lookup_resp, resp_fire, beat_hit;

  assign idx_r = addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign off_r = addr_q[OFFSET_W-1:2];
  assign tag_r = addr_q[31:INDEX_W+OFFSET_W];

  // Uncached fetches never hit, even if the line happens to be resident
  assign hit = (state_q == ICACHE_S_LOOKUP) & set_vld_q[idx_r] &
               (ram_tag == tag_r) & ~unc_q;

  assign addr_ok = valid & rstn &
                   ((state_q == ICACHE_S_IDLE) |
                    ((state_q == ICACHE_S_LOOKUP) & (hit | cancel)));

  // A cancel arriving in the RESP cycle itself also kills the response
  assign lookup_resp = hit & ~cancel;
  assign resp_fire   = (state_q == ICACHE_S_RESP) & ~dropped_q & ~cancel;
  assign data_ok     = lookup_resp | resp_fire;
  assign rdata       = lookup_resp ? ram_line[off_r] :
                       resp_fire   ? cap_q : rdata_q;

  assign rd_req  = (state_q == ICACHE_S_MISS);
  assign rd_type = rd_req ? (unc_q ? RD_TYPE_WORD : RD_TYPE_LINE) : 3'b000;
  assign rd_addr = !rd_req ? 32'h0 :
                   unc_q   ? addr_q : {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};

  // Uncached returns a single word, so beat 0 is always the one wanted
  assign beat_hit = unc_q ? (cnt_q == '0) : (cnt_q == off_r);

  icache_line_ram #(
    .INDEX_W  (INDEX_W),
    .OFFSET_W (OFFSET_W)
  ) u_ram (
    .clk     (clk),
    .re      (addr_ok),
    .r_idx   (iaddr[INDEX_W+OFFSET_W-1:OFFSET_W]),
    .r_tag   (ram_tag),
    .r_line  (ram_line),
    .we_word ((state_q == ICACHE_S_REFILL) & ret_valid & ~unc_q),
    .w_idx   (idx_r),
    .w_word  (cnt_q),
    .w_data  (ret_data),
    .we_tag  ((state_q == ICACHE_S_REFILL) & ret_valid & ret_last & ~unc_q),
    .w_tag   (tag_r)
  );

  // Next-state and datapath register updates
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    unc_d     = unc_q;
    set_vld_d = set_vld_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    dropped_d = dropped_q;
    if (addr_ok) begin
      addr_d = iaddr;
      unc_d  = uncached;
    end
    case (state_q)
      ICACHE_S_IDLE: if (addr_ok) state_d = ICACHE_S_LOOKUP;
      ICACHE_S_LOOKUP: begin
        if (addr_ok)             state_d = ICACHE_S_LOOKUP;
        else if (hit || cancel)  state_d = ICACHE_S_IDLE;
        else                     state_d = ICACHE_S_MISS;
      end
      ICACHE_S_MISS: begin
        cnt_d = '0;
        if (cancel) dropped_d = 1'b1;
        if (rd_rdy) state_d = ICACHE_S_REFILL;
      end
      ICACHE_S_REFILL: begin
        if (cancel) dropped_d = 1'b1;
        if (ret_valid) begin
          cnt_d = cnt_q + CNT_ONE;
          if (beat_hit) cap_d = ret_data;
          if (ret_last) begin
            if (!unc_q) set_vld_d[idx_r] = 1'b1;
            state_d = ICACHE_S_RESP;
          end
        end
      end
      ICACHE_S_RESP: begin
        dropped_d = 1'b0;
        state_d   = ICACHE_S_IDLE;
      end
      default: state_d = ICACHE_S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ICACHE_S_IDLE;
      addr_q    <= '0;
      unc_q     <= 1'b0;
      set_vld_q <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      rdata_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      unc_q     <= unc_d;
      set_vld_q <= set_vld_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata;
      dropped_q <= dropped_d;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Counters wrap naturally on overflow
  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'b0, lookup_resp};
    miss_cnt_d = miss_cnt_q +
                 {31'b0, (state_q == ICACHE_S_LOOKUP) && (state_d == ICACHE_S_MISS)};
  end

  // Performance counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_resp.sv
// Self-checking bench for icache_resp: directed scenarios plus a randomized
// fetch stream, checked against a transaction-level cache/memory model.
module tb_icache_resp;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        valid = 1'b0, uncached = 1'b0, cancel = 1'b0;
  logic [31:0] iaddr = '0;
  logic        rd_rdy = 1'b0, ret_valid = 1'b0, ret_last = 1'b0;
  logic [31:0] ret_data = '0;
  logic        addr_ok, data_ok, rd_req;
  logic [31:0] rdata, rd_addr;
  logic [2:0]  rd_type;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_resp #(.INDEX_W(6), .OFFSET_W(4)) dut (
    .clk(clk), .rstn(rstn), .valid(valid), .iaddr(iaddr), .uncached(uncached),
    .cancel(cancel), .addr_ok(addr_ok), .rdata(rdata), .data_ok(data_ok),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
`ifdef ICACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: cache contents as plain arrays, memory as address functions
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  logic [31:0] m_data  [64][4];
  int          m_hits = 0, m_miss = 0;

  bit          chk_en = 1'b0;
  logic        exp_addr_ok, exp_data_ok, exp_rd_req;
  logic [31:0] exp_rdata, exp_rd_addr;
  logic [2:0]  exp_rd_type;

  int          n_chk = 0, n_pass = 0;
  int          obs_dok = 0, obs_rdreq = 0;
  logic [31:0] obs_rdata = '0, obs_rd_addr = '0;
  logic [2:0]  obs_rd_type = '0;
  logic [31:0] dok_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] cword(input logic [31:0] a);
    if (a[31:4] == 28'h1c00000) return 32'hA0 + {30'b0, a[3:2]};
    return {a[15:2], 2'b01, ~a[15:0]};
  endfunction

  function automatic logic [31:0] uword(input logic [31:0] a);
    if (a == 32'h1c000008) return 32'h55;
    return a ^ 32'hC3C3_0000;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0: t = 32'h1c000000;
      1: t = 32'h1c000400;
      2: t = 32'h1c000800;
      default: t = 32'h20000000;
    endcase
    return t + 32'($urandom_range(0, 3)) * 16 + 32'($urandom_range(0, 3)) * 4;
  endfunction

  // Single compare process: DUT outputs against model expectations each cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr_ok", {31'b0, addr_ok}, {31'b0, exp_addr_ok});
      chk("data_ok", {31'b0, data_ok}, {31'b0, exp_data_ok});
      if (exp_data_ok) chk("rdata", rdata, exp_rdata);
      chk("rd_req", {31'b0, rd_req}, {31'b0, exp_rd_req});
      if (exp_rd_req) begin
        chk("rd_type", {29'b0, rd_type}, {29'b0, exp_rd_type});
        chk("rd_addr", rd_addr, exp_rd_addr);
      end
    end
    if (data_ok) begin obs_dok++; obs_rdata = rdata; dok_q.push_back(rdata); end
    if (rd_req)  begin obs_rdreq++; obs_rd_addr = rd_addr; obs_rd_type = rd_type; end
  end

  task automatic defaults();
    valid = 1'b0; cancel = 1'b0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
    ret_data = $urandom; iaddr = $urandom & 32'hFFFF_FFFC; uncached = $urandom_range(0, 1);
    exp_addr_ok = 1'b0; exp_data_ok = 1'b0; exp_rd_req = 1'b0;
    exp_rdata = '0; exp_rd_addr = '0; exp_rd_type = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Fetch-stage pressure while the cache is busy; must not be accepted
  task automatic noise();
    if ($urandom_range(0, 3) == 0) valid = 1'b1;
  endtask

  task automatic accept(input logic [31:0] a, input bit unc);
    defaults(); valid = 1'b1; iaddr = a; uncached = unc; exp_addr_ok = 1'b1;
    step();
  endtask

  // Drive an accepted request from LOOKUP to completion.
  // cmode: 0 none, 1 cancel in LOOKUP, 2 in MISS, 3 during REFILL, 4 in RESP
  task automatic complete(input logic [31:0] a, input bit unc, input int cmode,
                          input int dly, input bit nxt, input logic [31:0] na,
                          input bit nunc, output bit taken);
    bit hit, dropped;
    int nb, beat, cyc, ccyc;
    logic [5:0]  ix;
    logic [31:0] lb;
    ix = a[9:4]; lb = {a[31:4], 4'h0};
    hit = !unc && m_valid[ix] && (m_tag[ix] == a[31:10]);
    taken = 1'b0; dropped = 1'b0;
    defaults();
    if (cmode == 1) cancel = 1'b1;
    if (hit || cmode == 1) begin
      if (nxt) begin valid = 1'b1; iaddr = na; uncached = nunc; exp_addr_ok = 1'b1; taken = 1'b1; end
      if (cmode != 1) begin exp_data_ok = 1'b1; exp_rdata = m_data[ix][a[3:2]]; m_hits++; end
      step();
      return;
    end
    noise(); step();
    m_miss++;
    for (int k = 0; k <= dly; k++) begin
      defaults(); noise();
      exp_rd_req = 1'b1; exp_rd_type = unc ? 3'b010 : 3'b100; exp_rd_addr = unc ? a : lb;
      rd_rdy = (k == dly);
      if (cmode == 2 && k == 0) begin cancel = 1'b1; dropped = 1'b1; end
      step();
    end
    nb = unc ? 1 : 4; beat = 0; cyc = 0; ccyc = $urandom_range(0, 3);
    while (beat < nb) begin
      defaults(); noise();
      if (cmode == 3 && cyc == ccyc) begin cancel = 1'b1; dropped = 1'b1; end
      ret_valid = ($urandom_range(0, 3) != 0);
      if (ret_valid) begin
        ret_data = unc ? uword(a) : cword(lb + 32'(beat) * 4);
        ret_last = (beat == nb - 1);
        beat++;
      end
      cyc++;
      step();
    end
    if (!unc) begin
      m_valid[ix] = 1'b1; m_tag[ix] = a[31:10];
      for (int w = 0; w < 4; w++) m_data[ix][w] = cword(lb + 32'(w) * 4);
    end
    defaults();
    if (cmode == 4) begin cancel = 1'b1; dropped = 1'b1; end
    exp_data_ok = !dropped; exp_rdata = unc ? uword(a) : cword(a);
    step();
  endtask

  task automatic fetch(input logic [31:0] a, input bit unc, input int cmode);
    bit tk;
    accept(a, unc);
    complete(a, unc, cmode, $urandom_range(0, 2), 1'b0, '0, 1'b0, tk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, d0;
    bit tk, pend;
    logic [31:0] pa;
    bit pu;
    for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
    defaults();
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    chk_en = 1'b1;
    chk("reset rdata", rdata, 32'h0);
    chk("reset rd_addr", rd_addr, 32'h0);
    chk("reset rd_type", {29'b0, rd_type}, 32'h0);
    step();

    // Cold fetch
    fetch(32'h1c000000, 1'b0, 0);
    chk("cold rd_addr", obs_rd_addr, 32'h1c000000);
    chk("cold rd_type", {29'b0, obs_rd_type}, 32'h4);
    chk("cold rdata", obs_rdata, 32'hA0);

    // Back-to-back hits
    dok_q.delete(); r0 = obs_rdreq;
    accept(32'h1c000004, 1'b0);
    complete(32'h1c000004, 1'b0, 0, 0, 1'b1, 32'h1c000008, 1'b0, tk);
    complete(32'h1c000008, 1'b0, 0, 0, 1'b0, '0, 1'b0, tk);
    chk("pair count", dok_q.size(), 2);
    if (dok_q.size() >= 2) begin
      chk("pair first", dok_q[0], 32'hA1);
      chk("pair second", dok_q[1], 32'hA2);
    end
    chk("pair no rd_req", obs_rdreq - r0, 0);

    // Uncached fetch, then cached of the same address still hits
    fetch(32'h1c000008, 1'b1, 0);
    chk("unc rd_type", {29'b0, obs_rd_type}, 32'h2);
    chk("unc rd_addr", obs_rd_addr, 32'h1c000008);
    chk("unc rdata", obs_rdata, 32'h55);
    r0 = obs_rdreq;
    fetch(32'h1c000008, 1'b0, 0);
    chk("after unc hit rdata", obs_rdata, 32'hA2);
    chk("after unc no rd_req", obs_rdreq - r0, 0);

    // Cancel during refill: no response, line still installed
    d0 = obs_dok;
    fetch(32'h1c000100, 1'b0, 3);
    chk("cancel no data_ok", obs_dok - d0, 0);
    r0 = obs_rdreq;
    fetch(32'h1c000100, 1'b0, 0);
    chk("cancel line hits", obs_rdreq - r0, 0);

    // Conflict eviction
    fetch(32'h1c000400, 1'b0, 0);
    r0 = obs_rdreq;
    fetch(32'h1c000000, 1'b0, 0);
    chk("conflict misses", {31'b0, obs_rdreq != r0}, 32'h1);

    // Reset in the middle of a refill
    accept(32'h1c000300, 1'b0);
    defaults(); step();
    m_miss++;
    defaults(); exp_rd_req = 1'b1; exp_rd_type = 3'b100; exp_rd_addr = 32'h1c000300;
    rd_rdy = 1'b1; step();
    for (int b = 0; b < 2; b++) begin
      defaults(); ret_valid = 1'b1; ret_data = cword(32'h1c000300 + 32'(b) * 4); step();
    end
    defaults(); rstn = 1'b0; ret_valid = 1'b1; valid = 1'b1; iaddr = 32'h1c000300; step();
    rstn = 1'b1;
    for (int s = 0; s < 64; s++) m_valid[s] = 1'b0;
    m_hits = 0; m_miss = 0;
    defaults(); ret_valid = 1'b1; ret_data = 32'hDEAD0000; step();
    defaults(); ret_valid = 1'b1; ret_last = 1'b1; step();
    r0 = obs_rdreq;
    fetch(32'h1c000300, 1'b0, 0);
    chk("refetch after reset misses", {31'b0, obs_rdreq != r0}, 32'h1);
    chk("refetch rdata", obs_rdata, cword(32'h1c000300));

    // Randomized stream
    pend = 1'b0; pa = '0; pu = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, na;
      bit u, nu, nx;
      int cm;
      if (!pend) begin
        a = rnd_addr(); u = ($urandom_range(0, 5) == 0);
        accept(a, u);
      end else begin
        a = pa; u = pu;
      end
      cm = $urandom_range(0, 9);
      if (cm > 4) cm = 0;
      na = rnd_addr(); nu = ($urandom_range(0, 5) == 0); nx = $urandom_range(0, 1);
      complete(a, u, cm, $urandom_range(0, 3), nx, na, nu, tk);
      pend = tk; pa = na; pu = nu;
      if (!pend && $urandom_range(0, 3) == 0) begin
        defaults(); ret_valid = $urandom_range(0, 1); step();
      end
    end
    if (pend) complete(pa, pu, 0, 0, 1'b0, '0, 1'b0, tk);
    defaults(); step();

`ifdef ICACHE_PERF_EN
    chk("hit_cnt", hit_cnt, 32'(m_hits));
    chk("miss_cnt", miss_cnt, 32'(m_miss));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
